cpu_controller: RTL and testbench

Moore state machine that sequences the Lab 6 register-file/ALU datapath inside `cpu`. It sits between the instruction decoder and the datapath. It accepts a start pulse `s` and walks the datapath through read, compute and write-back. It drives every datapath load and select line, and raises `w` while idle.

---
 rtl/cpu_controller_pkg.sv | 86 ++++++++
 rtl/cpu_controller.sv | 100 ++++++++++
 tb/tb_cpu_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the cpu_controller sequencer.
//   - state_e   : 3-bit binary state codes of the controller FSM
//   - INSTR_*   : {opcode,op} instruction codes recognised by the controller
//   - NSEL_* / VSEL_* : one-hot register-select and write-back-source codes
//   - ctrl_t    : bundle of every datapath control line driven by the FSM
//   - ctrlFor() : Moore output decode from a state and a latched instruction
package cpu_controller_pkg;

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_GET_A     = 3'd2,
    ST_GET_B     = 3'd3,
    ST_CALC      = 3'd4,
    ST_WRITE_REG = 3'd5,
    ST_WRITE_IMM = 3'd6
  } state_e;

  localparam logic [4:0] INSTR_MOV_IMM = 5'b110_10;
  localparam logic [4:0] INSTR_MOV_REG = 5'b110_00;
  localparam logic [4:0] INSTR_ADD     = 5'b101_00;
  localparam logic [4:0] INSTR_CMP     = 5'b101_01;
  localparam logic [4:0] INSTR_AND     = 5'b101_10;
  localparam logic [4:0] INSTR_MVN     = 5'b101_11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [3:0] VSEL_NONE   = 4'b0000;
  localparam logic [3:0] VSEL_MDATA  = 4'b0001;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0010;
  localparam logic [3:0] VSEL_PC     = 4'b0100;
  localparam logic [3:0] VSEL_C      = 4'b1000;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
  } ctrl_t;

  // Everything not named for a state stays 0, so start from all-zero and
  // only raise the lines that state owns.
  function automatic ctrl_t ctrlFor(input state_e state, input logic [4:0] instr);
    ctrl_t c;
    c = '0;
    case (state)
      ST_WAIT: c.w = 1'b1;
      ST_GET_A: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
      end
      ST_GET_B: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
      end
      ST_CALC: begin
        c.loadc = 1'b1;
        // MOV reg passes B straight through by zeroing the A operand.
        c.asel  = (instr == INSTR_MOV_REG);
        c.loads = (instr == INSTR_CMP);
      end
      ST_WRITE_REG: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
      end
      ST_WRITE_IMM: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_SXIMM8;
        c.write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing the register-file/ALU datapath.
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  synchronous active-high reset, forces WAIT
//   s      in  1  start request, only looked at in WAIT
//   opcode in  3  instruction bits [15:13]
//   op     in  2  instruction bits [12:11]
//   w      out 1  high only while idle in WAIT
//   nsel   out 3  one-hot register select (001 Rn, 010 Rd, 100 Rm)
//   vsel   out 4  one-hot write-back source (0001 mdata .. 1000 C)
//   loada, loadb, loadc, loads  out 1  datapath register enables
//   asel   out 1  forces ALU A operand to zero
//   bsel   out 1  selects sximm5 for ALU B; never used here, tied low
//   write  out 1  register-file write enable
module cpu_controller
  import cpu_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [3:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write
);

  state_e     state_q, state_d;
  logic [4:0] instr_q, instr_d;
  ctrl_t      ctrl_q, ctrl_d;

  // Next-state logic. The instruction is captured only on the edge leaving
  // WAIT, so the decoder may change opcode/op freely mid-sequence.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      ST_WAIT: begin
        if (s) begin
          state_d = ST_DECODE;
          instr_d = {opcode, op};
        end
      end
      ST_DECODE: begin
        case (instr_q)
          INSTR_MOV_IMM:                    state_d = ST_WRITE_IMM;
          INSTR_MOV_REG, INSTR_MVN:         state_d = ST_GET_B;
          INSTR_ADD, INSTR_CMP, INSTR_AND:  state_d = ST_GET_A;
          default:                          state_d = ST_WAIT;
        endcase
      end
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_CALC;
      ST_CALC:      state_d = (instr_q == INSTR_CMP) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_d = ST_WAIT;
      ST_WRITE_IMM: state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // Outputs are decoded one cycle early from the next state and the
  // instruction that will be latched, then registered, so they line up
  // exactly with the state they belong to and never glitch.
  always_comb begin
    ctrl_d = ctrlFor(state_d, instr_d);
  end

  // Single state register; reset wins over any in-flight state and drops
  // write/loads on the very edge it is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
      instr_q <= '0;
      ctrl_q  <= ctrlFor(ST_WAIT, 5'b0);
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign w     = ctrl_q.w;
  assign nsel  = ctrl_q.nsel;
  assign vsel  = ctrl_q.vsel;
  assign loada = ctrl_q.loada;
  assign loadb = ctrl_q.loadb;
  assign loadc = ctrl_q.loadc;
  assign loads = ctrl_q.loads;
  assign asel  = ctrl_q.asel;
  assign bsel  = ctrl_q.bsel;
  assign write = ctrl_q.write;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller: walks each instruction class,
// the illegal code, opcode changes mid-sequence, reset mid-instruction and
// a held start request, comparing all outputs after every clock edge.
module tb_cpu_controller;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [3:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write;

  int total = 0;
  int bad   = 0;

  // Expected output vectors, packed as
  // {w, nsel[2:0], vsel[3:0], loada, loadb, loadc, loads, asel, bsel, write}
  localparam logic [14:0] EXP_WAIT     = {1'b1, 3'b000, 4'b0000, 7'b0000000};
  localparam logic [14:0] EXP_IDLE     = {1'b0, 3'b000, 4'b0000, 7'b0000000};
  localparam logic [14:0] EXP_GET_A    = {1'b0, 3'b001, 4'b0000, 7'b1000000};
  localparam logic [14:0] EXP_GET_B    = {1'b0, 3'b100, 4'b0000, 7'b0100000};
  localparam logic [14:0] EXP_CALC     = {1'b0, 3'b000, 4'b0000, 7'b0010000};
  localparam logic [14:0] EXP_CALC_CMP = {1'b0, 3'b000, 4'b0000, 7'b0011000};
  localparam logic [14:0] EXP_CALC_MOV = {1'b0, 3'b000, 4'b0000, 7'b0010100};
  localparam logic [14:0] EXP_WR_REG   = {1'b0, 3'b010, 4'b1000, 7'b0000001};
  localparam logic [14:0] EXP_WR_IMM   = {1'b0, 3'b001, 4'b0010, 7'b0000001};

  logic [14:0] observed;
  assign observed = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write};

  cpu_controller dut (
    .clk    (clk),
    .reset  (reset),
    .s      (s),
    .opcode (opcode),
    .op     (op),
    .w      (w),
    .nsel   (nsel),
    .vsel   (vsel),
    .loada  (loada),
    .loadb  (loadb),
    .loadc  (loadc),
    .loads  (loads),
    .asel   (asel),
    .bsel   (bsel),
    .write  (write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs just after a rising edge, well clear of the next one.
  task automatic applyStimulus(input logic sIn, input logic [2:0] opcodeIn, input logic [1:0] opIn);
    s      = sIn;
    opcode = opcodeIn;
    op     = opIn;
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 3'b000, 2'b00);

    // Reset and idle
    stepEdge();
    checkOutput("reset_wait", EXP_WAIT);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stepEdge();
      checkOutput($sformatf("idle_%0d", i), EXP_WAIT);
    end

    // MOV R0,#7: 3 edges
    applyStimulus(1'b1, 3'b110, 2'b10);
    stepEdge(); checkOutput("movimm_decode", EXP_IDLE);
    applyStimulus(1'b0, 3'b110, 2'b10);
    stepEdge(); checkOutput("movimm_write", EXP_WR_IMM);
    stepEdge(); checkOutput("movimm_wait", EXP_WAIT);

    // ADD: 6 edges
    applyStimulus(1'b1, 3'b101, 2'b00);
    stepEdge(); checkOutput("add_decode", EXP_IDLE);
    applyStimulus(1'b0, 3'b101, 2'b00);
    stepEdge(); checkOutput("add_geta", EXP_GET_A);
    stepEdge(); checkOutput("add_getb", EXP_GET_B);
    stepEdge(); checkOutput("add_calc", EXP_CALC);
    stepEdge(); checkOutput("add_wreg", EXP_WR_REG);
    stepEdge(); checkOutput("add_wait", EXP_WAIT);

    // CMP: 5 edges, loads in CALC, no write
    applyStimulus(1'b1, 3'b101, 2'b01);
    stepEdge(); checkOutput("cmp_decode", EXP_IDLE);
    applyStimulus(1'b0, 3'b101, 2'b01);
    stepEdge(); checkOutput("cmp_geta", EXP_GET_A);
    stepEdge(); checkOutput("cmp_getb", EXP_GET_B);
    stepEdge(); checkOutput("cmp_calc", EXP_CALC_CMP);
    stepEdge(); checkOutput("cmp_wait", EXP_WAIT);

    // MOV reg with opcode changed to ADD while in GET_B
    applyStimulus(1'b1, 3'b110, 2'b00);
    stepEdge(); checkOutput("movreg_decode", EXP_IDLE);
    applyStimulus(1'b0, 3'b110, 2'b00);
    stepEdge(); checkOutput("movreg_getb", EXP_GET_B);
    applyStimulus(1'b0, 3'b101, 2'b00);
    stepEdge(); checkOutput("movreg_calc", EXP_CALC_MOV);
    stepEdge(); checkOutput("movreg_wreg", EXP_WR_REG);
    stepEdge(); checkOutput("movreg_wait", EXP_WAIT);

    // MVN: 5 edges, no asel, no loads
    applyStimulus(1'b1, 3'b101, 2'b11);
    stepEdge(); checkOutput("mvn_decode", EXP_IDLE);
    applyStimulus(1'b0, 3'b101, 2'b11);
    stepEdge(); checkOutput("mvn_getb", EXP_GET_B);
    stepEdge(); checkOutput("mvn_calc", EXP_CALC);
    stepEdge(); checkOutput("mvn_wreg", EXP_WR_REG);
    stepEdge(); checkOutput("mvn_wait", EXP_WAIT);

    // Illegal 111_00: 2 edges, no enables
    applyStimulus(1'b1, 3'b111, 2'b00);
    stepEdge(); checkOutput("illegal_decode", EXP_IDLE);
    applyStimulus(1'b0, 3'b111, 2'b00);
    stepEdge(); checkOutput("illegal_wait", EXP_WAIT);

    // Reset while an ADD is in CALC
    applyStimulus(1'b1, 3'b101, 2'b00);
    stepEdge(); checkOutput("rst_add_decode", EXP_IDLE);
    applyStimulus(1'b0, 3'b101, 2'b00);
    stepEdge(); checkOutput("rst_add_geta", EXP_GET_A);
    stepEdge(); checkOutput("rst_add_getb", EXP_GET_B);
    stepEdge(); checkOutput("rst_add_calc", EXP_CALC);
    reset = 1'b1;
    stepEdge(); checkOutput("rst_add_wait", EXP_WAIT);
    reset = 1'b0;
    stepEdge(); checkOutput("rst_add_stay0", EXP_WAIT);
    stepEdge(); checkOutput("rst_add_stay1", EXP_WAIT);

    // Reset overrides a pending start request
    applyStimulus(1'b1, 3'b110, 2'b10);
    reset = 1'b1;
    stepEdge(); checkOutput("rst_over_s", EXP_WAIT);
    reset = 1'b0;
    applyStimulus(1'b0, 3'b110, 2'b10);
    stepEdge(); checkOutput("rst_over_s_idle", EXP_WAIT);

    // Hold s=1 through an AND: restarts immediately after WAIT
    applyStimulus(1'b1, 3'b101, 2'b10);
    stepEdge(); checkOutput("hold_decode", EXP_IDLE);
    stepEdge(); checkOutput("hold_geta", EXP_GET_A);
    stepEdge(); checkOutput("hold_getb", EXP_GET_B);
    stepEdge(); checkOutput("hold_calc", EXP_CALC);
    stepEdge(); checkOutput("hold_wreg", EXP_WR_REG);
    stepEdge(); checkOutput("hold_wait", EXP_WAIT);
    stepEdge(); checkOutput("hold_redecode", EXP_IDLE);
    applyStimulus(1'b0, 3'b101, 2'b10);
    stepEdge(); checkOutput("hold_regeta", EXP_GET_A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
